// File: rtl/pc_skip_unit_if.sv
// Request/commit bundle for pc_skip_unit: the master issues STEP/SKIPCOND/JUMP/NOP
// requests, the slave (the unit) returns the committed program counter.
interface pc_skip_unit_if #(
    parameter int PC_W = 32,
    parameter int AC_W = 16
);
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [2:0]             req_cond;
    logic signed [AC_W-1:0] req_ac;
    logic [PC_W-1:0]        req_target;
    logic [PC_W-1:0]        pc;
    logic                   pc_valid;
    logic                   skipped;

    modport master (
        output req_valid, req_op, req_cond, req_ac, req_target,
        input  req_ready, pc, pc_valid, skipped
    );

    modport slave (
        input  req_valid, req_op, req_cond, req_ac, req_target,
        output req_ready, pc, pc_valid, skipped
    );
endinterface

// File: rtl/pc_skip_unit.sv
// Program-counter sequencer with conditional skip (IDLE -> EVAL -> COMMIT per request).
// Define PC_SKIP_STATS_EN to add the saturating taken-skip counter port skip_count.
module pc_skip_unit #(
    parameter int              PC_W      = 32,
    parameter int              AC_W      = 16,
    parameter logic [PC_W-1:0] PC_RESET  = '0,
    parameter int              SKIP_DIST = 1
) (
    input  logic              clk,
    input  logic              rst,
    pc_skip_unit_if.slave     bus
`ifdef PC_SKIP_STATS_EN
    ,
    output logic [15:0]       skip_count
`endif
);
    localparam logic [1:0] OP_STEP = 2'd0;
    localparam logic [1:0] OP_SKIP = 2'd1;
    localparam logic [1:0] OP_JUMP = 2'd2;
    localparam logic [PC_W-1:0] SKIP_STEP = PC_W'(SKIP_DIST + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, COMMIT = 2'd2} state_t;

    state_t state_reg, state_next;
    logic   ready, eval_en, commit_en, accept;

    logic [1:0]      op_reg;
    logic [2:0]      cond_reg;
    logic [PC_W-1:0] target_reg;
    logic            lt_reg, eq_reg, gt_reg;
    logic [PC_W-1:0] next_pc_reg;
    logic            taken_reg;
    logic [PC_W-1:0] pc_reg;
    logic            pc_valid_reg;
    logic            skipped_reg;

    logic            ac_lt, ac_eq;

    assign accept = bus.req_valid && ready;
    assign ac_lt  = bus.req_ac[AC_W-1];
    assign ac_eq  = (bus.req_ac == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EVAL;
            EVAL:    state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready     = 1'b0;
        eval_en   = 1'b0;
        commit_en = 1'b0;
        case (state_reg)
            IDLE:    ready     = 1'b1;
            EVAL:    eval_en   = 1'b1;
            COMMIT:  commit_en = 1'b1;
            default: ready     = 1'b0;
        endcase
    end

    // Request fields are captured once at accept so later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg     <= '0;
            cond_reg   <= '0;
            target_reg <= '0;
            lt_reg     <= 1'b0;
            eq_reg     <= 1'b0;
            gt_reg     <= 1'b0;
        end else if (accept) begin
            op_reg     <= bus.req_op;
            cond_reg   <= bus.req_cond;
            target_reg <= bus.req_target;
            lt_reg     <= ac_lt;
            eq_reg     <= ac_eq;
            gt_reg     <= !ac_lt && !ac_eq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_pc_reg <= '0;
            taken_reg   <= 1'b0;
        end else if (eval_en) begin
            taken_reg <= 1'b0;
            case (op_reg)
                OP_STEP: next_pc_reg <= pc_reg + 1'b1;
                OP_SKIP: begin
                    if (|(cond_reg & {gt_reg, eq_reg, lt_reg})) begin
                        next_pc_reg <= pc_reg + SKIP_STEP;
                        taken_reg   <= 1'b1;
                    end else begin
                        next_pc_reg <= pc_reg + 1'b1;
                    end
                end
                OP_JUMP: next_pc_reg <= target_reg;
                default: next_pc_reg <= pc_reg;
            endcase
        end
    end

    // Commit lands on the second edge after accept; the pulse is visible the
    // cycle after, while the FSM is already back in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= PC_RESET;
            pc_valid_reg <= 1'b0;
            skipped_reg  <= 1'b0;
        end else begin
            pc_valid_reg <= commit_en;
            skipped_reg  <= commit_en && taken_reg;
            if (commit_en) pc_reg <= next_pc_reg;
        end
    end

`ifdef PC_SKIP_STATS_EN
    logic [15:0] skip_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            skip_count_reg <= '0;
        else if (commit_en && taken_reg && (skip_count_reg != 16'hFFFF))
            skip_count_reg <= skip_count_reg + 16'd1;
    end

    assign skip_count = skip_count_reg;
`endif

    assign bus.req_ready = ready;
    assign bus.pc        = pc_reg;
    assign bus.pc_valid  = pc_valid_reg;
    assign bus.skipped   = skipped_reg;
endmodule

// File: tb/tb_pc_skip_unit.sv
// Directed, table-driven bench for pc_skip_unit plus hand sequences for reset abort
// and (with PC_SKIP_STATS_EN) the saturating skip counter.
module tb_pc_skip_unit;
    localparam int PC_W = 32;
    localparam int AC_W = 16;

    localparam logic [1:0] STEP = 2'd0;
    localparam logic [1:0] SKIP = 2'd1;
    localparam logic [1:0] JUMP = 2'd2;
    localparam logic [1:0] NOP  = 2'd3;

    typedef struct {
        logic [1:0]      op;
        logic [2:0]      cond;
        logic [AC_W-1:0] ac;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] exp_pc;
        logic            exp_skipped;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    pc_skip_unit_if #(.PC_W(PC_W), .AC_W(AC_W)) ifc ();

`ifdef PC_SKIP_STATS_EN
    logic [15:0] skip_count;
`endif

    pc_skip_unit #(
        .PC_W(PC_W), .AC_W(AC_W), .PC_RESET(32'd0), .SKIP_DIST(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
`ifdef PC_SKIP_STATS_EN
        ,
        .skip_count(skip_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one request from a negedge and check the full 3-cycle timeline.
    task automatic do_req(input vec_t v, input int idx);
        int n = 0;
        while (!ifc.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d ready_before", idx), 64'(ifc.req_ready), 64'd1);
        ifc.req_valid  = 1'b1;
        ifc.req_op     = v.op;
        ifc.req_cond   = v.cond;
        ifc.req_ac     = v.ac;
        ifc.req_target = v.target;
        @(posedge clk); #1;
        ifc.req_valid  = 1'b0;
        ifc.req_op     = ~v.op;
        ifc.req_cond   = ~v.cond;
        ifc.req_ac     = ~v.ac;
        ifc.req_target = ~v.target;
        chk($sformatf("v%0d eval_ready_pv", idx), {62'd0, ifc.req_ready, ifc.pc_valid}, 64'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d commit_ready_pv", idx), {62'd0, ifc.req_ready, ifc.pc_valid}, 64'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d pc_valid", idx), 64'(ifc.pc_valid), 64'd1);
        chk($sformatf("v%0d pc", idx), 64'(ifc.pc), 64'(v.exp_pc));
        chk($sformatf("v%0d skipped", idx), 64'(ifc.skipped), 64'(v.exp_skipped));
        $display("[TB] v%0d op=%0d cond=%b ac=%h -> pc=%h skipped=%0b",
                 idx, v.op, v.cond, v.ac, ifc.pc, ifc.skipped);
        @(negedge clk);
    endtask

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{STEP, 3'b000, 16'h0000, 32'h0,        32'd1,        1'b0};
        vecs[1]  = '{STEP, 3'b111, 16'h0000, 32'h0,        32'd2,        1'b0};
        vecs[2]  = '{STEP, 3'b000, 16'h1234, 32'h55,       32'd3,        1'b0};
        vecs[3]  = '{JUMP, 3'b000, 16'h0000, 32'd10,       32'd10,       1'b0};
        vecs[4]  = '{SKIP, 3'b001, 16'hFFFF, 32'h0,        32'd12,       1'b1};
        vecs[5]  = '{JUMP, 3'b111, 16'h0001, 32'd10,       32'd10,       1'b0};
        vecs[6]  = '{SKIP, 3'b001, 16'h0005, 32'h0,        32'd11,       1'b0};
        vecs[7]  = '{SKIP, 3'b010, 16'h0000, 32'h0,        32'd13,       1'b1};
        vecs[8]  = '{SKIP, 3'b100, 16'h7FFF, 32'h0,        32'd15,       1'b1};
        vecs[9]  = '{SKIP, 3'b000, 16'h8000, 32'h0,        32'd16,       1'b0};
        vecs[10] = '{SKIP, 3'b111, 16'h8000, 32'h0,        32'd18,       1'b1};
        vecs[11] = '{SKIP, 3'b100, 16'h0000, 32'h0,        32'd19,       1'b0};
        vecs[12] = '{SKIP, 3'b110, 16'hFFFF, 32'h0,        32'd20,       1'b0};
        vecs[13] = '{NOP,  3'b111, 16'h0003, 32'h77,       32'd20,       1'b0};
        vecs[14] = '{JUMP, 3'b000, 16'h0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        vecs[15] = '{STEP, 3'b000, 16'h0000, 32'h0,        32'h0,        1'b0};
        vecs[16] = '{JUMP, 3'b000, 16'h0000, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};
        vecs[17] = '{SKIP, 3'b111, 16'h0001, 32'h0,        32'h0,        1'b1};

        ifc.req_valid  = 1'b0;
        ifc.req_op     = STEP;
        ifc.req_cond   = 3'b000;
        ifc.req_ac     = '0;
        ifc.req_target = '0;

        repeat (2) @(negedge clk);
        chk("reset_pc", 64'(ifc.pc), 64'd0);
        chk("reset_pulses", {62'd0, ifc.pc_valid, ifc.skipped}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(ifc.req_ready), 64'd1);

        for (int i = 0; i < 18; i++) do_req(vecs[i], i);

`ifdef PC_SKIP_STATS_EN
        chk("skip_count_after_table", 64'(skip_count), 64'd5);
`endif

        // Abort a JUMP by asserting reset mid-EVAL; nothing may commit.
        do_req('{STEP, 3'b000, 16'h0, 32'h0, 32'd1, 1'b0}, 100);
        ifc.req_valid  = 1'b1;
        ifc.req_op     = JUMP;
        ifc.req_target = 32'h100;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_async_pc", 64'(ifc.pc), 64'd0);
        chk("abort_pulse", 64'(ifc.pc_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 64'(ifc.req_ready), 64'd1);
        begin
            int pulses = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                if (ifc.pc_valid) pulses++;
            end
            chk("abort_no_pulse", 64'(pulses), 64'd0);
        end
        chk("abort_pc_after", 64'(ifc.pc), 64'd0);
        @(negedge clk);

`ifdef PC_SKIP_STATS_EN
        chk("skip_count_after_reset", 64'(skip_count), 64'd0);
        do_req('{SKIP, 3'b001, 16'h8001, 32'h0, 32'd2, 1'b1}, 101);
        do_req('{SKIP, 3'b100, 16'h8001, 32'h0, 32'd3, 1'b0}, 102);
        chk("skip_count_small", 64'(skip_count), 64'd1);
        force dut.skip_count_reg = 16'hFFFF;
        @(negedge clk);
        release dut.skip_count_reg;
        do_req('{SKIP, 3'b010, 16'h0000, 32'h0, 32'd5, 1'b1}, 103);
        chk("skip_count_saturate", 64'(skip_count), 64'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_skip_unit.md
PC_SKIP_UNIT -- requirements
Module: pc_skip_unit

Interface
REQ-001 Parameter PC_W, default 32, program-counter width in bits.
REQ-002 Parameter AC_W, default 16, accumulator width in bits; accumulator value is two's-complement signed.
REQ-003 Parameter PC_RESET, default 0, PC value loaded on reset.
REQ-004 Parameter SKIP_DIST, default 1, extra instructions skipped when a skip condition is taken.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  unit can accept a request.
REQ-009 req_op  in  2  0 STEP, 1 SKIPCOND, 2 JUMP, 3 NOP.
REQ-010 req_cond  in  3  condition mask {GT,EQ,LT} (bit2..bit0), used by SKIPCOND only.
REQ-011 req_ac  in  AC_W  accumulator value, signed.
REQ-012 req_target  in  PC_W  jump target, used by JUMP only.
REQ-013 pc  out  PC_W  current program counter, registered.
REQ-014 pc_valid  out  1  one-cycle pulse when pc has been committed.
REQ-015 skipped  out  1  one-cycle pulse coincident with pc_valid when a SKIPCOND was taken.
REQ-016 skip_count  out  16  taken-skip counter (present only per REQ-033).

Function
REQ-017 FSM states IDLE, EVAL, COMMIT; IDLE -> EVAL on accept, EVAL -> COMMIT unconditionally, COMMIT -> IDLE unconditionally.
REQ-018 req_ready SHALL be 1 exactly when state is IDLE; accept = req_valid && req_ready at a rising edge.
REQ-019 On accept, the unit SHALL latch req_op, req_target and three flags lt/eq/gt from signed comparison of req_ac against 0; later input changes SHALL have no effect.
REQ-020 In EVAL, the unit SHALL register next_pc and the taken flag; taken = |(req_cond & {gt,eq,lt}).
REQ-021 next_pc: STEP -> pc+1; SKIPCOND taken -> pc+1+SKIP_DIST; SKIPCOND not taken -> pc+1; JUMP -> req_target; NOP -> pc.
REQ-022 All PC arithmetic SHALL wrap modulo 2^PC_W (e.g. all-ones + 1 -> 0).
REQ-023 In COMMIT, pc SHALL take next_pc, pc_valid SHALL pulse 1 for one cycle, skipped SHALL equal taken for SKIPCOND and 0 otherwise.
REQ-024 Latency: pc/pc_valid SHALL update on the 2nd rising edge after the accept edge; max throughput one request per 3 cycles.
REQ-025 Mask 3'b000 SHALL never take; 3'b111 SHALL always take; multiple mask bits SHALL OR.
REQ-026 NOP SHALL still pass through EVAL/COMMIT and pulse pc_valid with pc unchanged.
REQ-027 pc_valid and skipped SHALL be 0 in IDLE and EVAL.

Reset
REQ-028 rst high SHALL immediately force state IDLE, pc = PC_RESET, pc_valid = 0, skipped = 0, skip_count = 0, internal latches = 0.
REQ-029 rst asserted in EVAL or COMMIT SHALL abort the request with no pc commit and no pulse.
REQ-030 After rst deasserts, req_ready SHALL be 1 and the first accept SHALL occur no earlier than the first rising edge with rst low.

Configuration
REQ-031 Macro PC_SKIP_STATS_EN controls the taken-skip statistics counter.
REQ-032 Without PC_SKIP_STATS_EN, port skip_count SHALL be absent and no counter logic SHALL exist.
REQ-033 With PC_SKIP_STATS_EN, skip_count SHALL increment by 1 on each COMMIT with skipped = 1, saturating at 16'hFFFF.

Verification
REQ-034 Reset then STEP x3 -> pc 0,1,2,3; pc_valid one pulse per request, 2 edges after each accept; req_ready low 2 cycles after each accept.
REQ-035 pc=10, SKIPCOND mask 3'b001, req_ac=16'hFFFF (-1) -> pc=12, skipped=1; same with req_ac=5 -> pc+1, skipped=0.
REQ-036 SKIPCOND masks 3'b010 with ac=0, 3'b100 with ac=16'h7FFF, 3'b000 with any ac, 3'b111 with ac=16'h8000 -> taken, taken, not taken, taken.
REQ-037 JUMP req_target=32'hFFFFFFFF then STEP -> pc 32'hFFFFFFFF then 0 (wrap); NOP -> pc unchanged with pc_valid pulse.
REQ-038 Assert rst during EVAL of a JUMP to 32'h100 -> pc = PC_RESET, no pc_valid pulse, req_ready = 1 after release.
REQ-039 With PC_SKIP_STATS_EN, 3 taken and 2 not-taken SKIPCONDs -> skip_count = 3; preload to 16'hFFFF via forced stimulus, one more taken skip -> stays 16'hFFFF.
